// File: rtl/seg_pkg.sv
// Shared segment-bus definitions: bit indices, glyph table, per-digit record.
// Imported by the scan decoder and the display driver's self-check.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high a..g pattern for nibble k lives at GLYPHS[k]
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] ALT_7     = 7'h27;
  localparam logic [6:0] ALT_9     = 7'h67;

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic       blank;
    logic       err;
  } dig_rec_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational active-high segment pattern -> {nibble, dp, blank, err}.
// SEG_DEC_ALT_GLYPH_EN also accepts the alternate 7 (27) and 9 (67) glyphs.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [7:0] pat_i,
  output dig_rec_t   rec_o
);

  logic hit;

  always_comb begin
    rec_o    = '0;
    hit      = 1'b0;
    rec_o.dp = pat_i[SEG_DP];
    for (int k = 0; k < 16; k++) begin
      if (pat_i[SEG_G:SEG_A] == GLYPHS[k]) begin
        rec_o.nib = 4'(k);
        hit       = 1'b1;
      end
    end
`ifdef SEG_DEC_ALT_GLYPH_EN
    if (pat_i[SEG_G:SEG_A] == ALT_7) begin
      rec_o.nib = 4'd7;
      hit       = 1'b1;
    end
    if (pat_i[SEG_G:SEG_A] == ALT_9) begin
      rec_o.nib = 4'd9;
      hit       = 1'b1;
    end
`endif
    if (pat_i[SEG_G:SEG_A] == SEG_BLANK) begin
      rec_o.blank = 1'b1;
    end else if (!hit) begin
      rec_o.err = 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds per-digit hex/dp/blank/err from a multiplexed 7-seg bus.
// A digit commits only after STABLE_CNT identical samples (ghost filter).
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int STABLE_CNT     = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic [7:0]              seg_in,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    update,
  output logic                    frame_done,
  output logic                    sel_err
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0] SC = 4'(STABLE_CNT);

  logic [7:0] cand_q [NUM_DIGITS];
  logic [7:0] cand_d [NUM_DIGITS];
  logic [3:0] cnt_q  [NUM_DIGITS];
  logic [3:0] cnt_d  [NUM_DIGITS];
  dig_rec_t   rec_q  [NUM_DIGITS];
  dig_rec_t   rec_d  [NUM_DIGITS];

  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic                  upd_q, upd_d;
  logic                  sel_q, sel_d;

  logic [7:0]    pat;
  logic [IW-1:0] idx;
  logic          onehot;
  logic          hold;
  logic          commit;
  dig_rec_t      dec;

  assign pat    = SEG_ACTIVE_LOW ? ~seg_in : seg_in;
  assign onehot = $onehot(dig_sel);

  always_comb begin
    idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_sel[k]) idx = IW'(k);
    end
  end

  seg_glyph_decode u_dec (
    .pat_i (pat),
    .rec_o (dec)
  );

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    rec_d  = rec_q;
    upd_d  = 1'b0;
    sel_d  = 1'b0;
    hold   = 1'b0;
    commit = 1'b0;
    // A full seen mask is reported this cycle and restarts at the edge
    seen_d = (&seen_q) ? '0 : seen_q;
    if (sample_valid && !onehot) begin
      sel_d = 1'b1;
    end else if (sample_valid) begin
      hold = (pat == cand_q[idx]) && (cnt_q[idx] != 4'd0);
      if (hold) begin
        if (cnt_q[idx] != SC) cnt_d[idx] = cnt_q[idx] + 4'd1;
      end else begin
        cand_d[idx] = pat;
        cnt_d[idx]  = 4'd1;
      end
      commit = (cnt_d[idx] == SC) && !(hold && cnt_q[idx] == SC);
      if (commit) begin
        rec_d[idx]  = dec;
        upd_d       = (dec != rec_q[idx]);
        seen_d[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        cand_q[k] <= '0;
        cnt_q[k]  <= '0;
        rec_q[k]  <= '{nib: 4'd0, dp: 1'b0, blank: 1'b1, err: 1'b0};
      end
      seen_q <= '0;
      upd_q  <= 1'b0;
      sel_q  <= 1'b0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      rec_q  <= rec_d;
      seen_q <= seen_d;
      upd_q  <= upd_d;
      sel_q  <= sel_d;
    end
  end

  always_comb begin
    value = '0;
    dp    = '0;
    blank = '0;
    err   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      value[4*k +: 4] = rec_q[k].nib;
      dp[k]           = rec_q[k].dp;
      blank[k]        = rec_q[k].blank;
      err[k]          = rec_q[k].err;
    end
  end

  assign update     = upd_q;
  assign frame_done = &seen_q;
  assign sel_err    = sel_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder (8 digits, 3-sample filter,
// active-low segments).
module tb_seg_scan_decoder;

  localparam int ND = 8;
  localparam int SC = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sv = 1'b0;
  logic [ND-1:0] sel = '0;
  logic [7:0]    seg = 8'hFF;
  logic [4*ND-1:0] value;
  logic [ND-1:0] dp, blank, err;
  logic          update, frame_done, sel_err;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .NUM_DIGITS     (ND),
    .STABLE_CNT     (SC),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .sample_valid (sv),
    .dig_sel      (sel),
    .seg_in       (seg),
    .value        (value),
    .dp           (dp),
    .blank        (blank),
    .err          (err),
    .update       (update),
    .frame_done   (frame_done),
    .sel_err      (sel_err)
  );

  typedef struct {
    logic [31:0] v;
    logic [7:0]  dp;
    logic [7:0]  bl;
    logic [7:0]  er;
    logic        up;
    logic        fr;
    logic        se;
  } exp_t;

  exp_t sbq[$];

  int nchk = 0;
  int nerr = 0;
  int nframe = 0;

  logic [7:0] mcand [ND];
  int         mcnt  [ND];
  logic [3:0] mv    [ND];
  logic [7:0] mdp, mbl, mer, mseen;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // {nibble, blank, err}
  function automatic logic [5:0] mdec(input logic [6:0] p);
    if (p == 7'h00) return 6'b0000_10;
    for (int n = 0; n < 16; n++)
      if (glyph(n) == p) return {4'(n), 2'b00};
`ifdef SEG_DEC_ALT_GLYPH_EN
    if (p == 7'h27) return {4'd7, 2'b00};
    if (p == 7'h67) return {4'd9, 2'b00};
`endif
    return 6'b0000_01;
  endfunction

  task automatic mreset();
    for (int i = 0; i < ND; i++) begin
      mcand[i] = '0;
      mcnt[i]  = 0;
      mv[i]    = '0;
    end
    mdp = '0; mbl = '1; mer = '0; mseen = '0;
  endtask

  task automatic model(input logic r, input logic v, input logic [7:0] s,
                       input logic [7:0] g, output exp_t e);
    logic [7:0] p;
    logic [5:0] dd;
    logic       c, ch, se;
    int         d;
    p = ~g; c = 1'b0; ch = 1'b0; se = 1'b0; d = 0;
    if (!r) begin
      mreset();
      e = '{v: 32'h0, dp: 8'h00, bl: 8'hFF, er: 8'h00, up: 1'b0, fr: 1'b0, se: 1'b0};
      return;
    end
    if (v && $countones(s) != 1) se = 1'b1;
    else if (v) begin
      for (int i = 0; i < ND; i++) if (s[i]) d = i;
      if (p == mcand[d] && mcnt[d] > 0) begin
        if (mcnt[d] < SC) begin
          mcnt[d]++;
          c = (mcnt[d] == SC);
        end
      end else begin
        mcand[d] = p;
        mcnt[d]  = 1;
        c = (SC == 1);
      end
      if (c) begin
        dd = mdec(p[6:0]);
        ch = (mv[d] != dd[5:2]) || (mdp[d] != p[7]) ||
             (mbl[d] != dd[1]) || (mer[d] != dd[0]);
        mv[d] = dd[5:2]; mdp[d] = p[7]; mbl[d] = dd[1]; mer[d] = dd[0];
      end
    end
    if (&mseen) mseen = '0;
    if (c) mseen[d] = 1'b1;
    for (int i = 0; i < ND; i++) e.v[4*i +: 4] = mv[i];
    e.dp = mdp; e.bl = mbl; e.er = mer;
    e.up = ch; e.fr = &mseen; e.se = se;
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] s,
                      input logic [7:0] g);
    exp_t e, x;
    @(negedge clk);
    rst_n = r; sv = v; sel = s; seg = g;
    model(r, v, s, g, e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    check("value", value, x.v);
    check("dp", 32'(dp), 32'(x.dp));
    check("blank", 32'(blank), 32'(x.bl));
    check("err", 32'(err), 32'(x.er));
    check("update", 32'(update), 32'(x.up));
    check("frame_done", 32'(frame_done), 32'(x.fr));
    check("sel_err", 32'(sel_err), 32'(x.se));
    if (frame_done) nframe++;
  endtask

  task automatic dig(input int d, input logic [7:0] g, input int n);
    repeat (n) step(1'b1, 1'b1, 8'(1 << d), g);
  endtask

  initial begin
    mreset();
    repeat (4) step(1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
    repeat (2) step(1'b1, 1'b0, 8'h00, 8'hFF);

    dig(0, 8'hC0, 2);
    check("no_commit_blank0", 32'(blank[0]), 32'd1);
    dig(0, 8'hC0, 1);
    check("commit_blank0", 32'(blank[0]), 32'd0);
    check("commit_upd0", 32'(update), 32'd1);
    dig(0, 8'hC0, 1);
    check("sat_noupd0", 32'(update), 32'd0);

    dig(2, 8'hF9, 2);
    dig(2, 8'hA4, 3);
    check("ghost_val2", 32'(value[11:8]), 32'd2);

    dig(5, 8'h7F, 3);
    check("dp5", 32'(dp[5]), 32'd1);
    check("blank5", 32'(blank[5]), 32'd1);
    dig(5, 8'h76, 3);
    check("err5", 32'(err[5]), 32'd1);
    check("val5", 32'(value[23:20]), 32'd0);

    step(1'b1, 1'b1, 8'h03, 8'hC0);
    check("sel_err_pulse", 32'(sel_err), 32'd1);
    step(1'b1, 1'b1, 8'h00, 8'hC0);

    nframe = 0;
    for (int d = 0; d < ND; d++) dig(d, ~{1'b0, glyph(d)}, 3);
    check("frame_pulses", nframe, 1);
    check("scan_val7", 32'(value[31:28]), 32'd7);

    dig(0, ~8'h27, 3);
`ifdef SEG_DEC_ALT_GLYPH_EN
    check("alt7_val", 32'(value[3:0]), 32'd7);
    check("alt7_err", 32'(err[0]), 32'd0);
`else
    check("alt7_err", 32'(err[0]), 32'd1);
`endif

    for (int r = 0; r < 3; r++) begin
      dig(1, 8'hF9, 1);
      dig(3, 8'hB0, 1);
    end
    check("ilv_val1", 32'(value[7:4]), 32'd1);
    check("ilv_val3", 32'(value[15:12]), 32'd3);

    repeat (3) step(1'b1, 1'b0, 8'($urandom), 8'($urandom));

    dig(4, 8'h99, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_blank", 32'(blank), 32'hFF);
    check("arst_value", value, 32'h0);
    check("arst_frame", 32'(frame_done), 32'd0);
    mreset();
    step(1'b1, 1'b0, 8'h00, 8'hFF);
    dig(4, 8'h99, 1);
    check("arst_nocommit4", 32'(blank[4]), 32'd1);
    dig(4, 8'h99, 2);
    check("arst_val4", 32'(value[19:16]), 32'd4);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
